// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU instruction sequencer.
//   state_e        : control-step state encoding (IDLE, T0..T6)
//   Op*            : 5-bit instruction opcodes
//   *Msb / *Lsb    : bit positions of the instruction-word fields
//   is_binary/is_unary/is_muldiv : opcode class helpers
package alu_op_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StT0,
        StT1,
        StT2,
        StT3,
        StT4,
        StT5,
        StT6
    } state_e;

    localparam int unsigned OpMsb = 31;
    localparam int unsigned OpLsb = 27;
    localparam int unsigned RaMsb = 26;
    localparam int unsigned RaLsb = 23;
    localparam int unsigned RbMsb = 22;
    localparam int unsigned RbLsb = 19;
    localparam int unsigned RcMsb = 18;
    localparam int unsigned RcLsb = 15;

    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpSub  = 5'b00100;
    localparam logic [4:0] OpAnd  = 5'b00101;
    localparam logic [4:0] OpOr   = 5'b00110;
    localparam logic [4:0] OpRor  = 5'b00111;
    localparam logic [4:0] OpRol  = 5'b01000;
    localparam logic [4:0] OpShr  = 5'b01001;
    localparam logic [4:0] OpShra = 5'b01010;
    localparam logic [4:0] OpShl  = 5'b01011;
    localparam logic [4:0] OpMul  = 5'b01111;
    localparam logic [4:0] OpDiv  = 5'b10000;
    localparam logic [4:0] OpNeg  = 5'b10001;
    localparam logic [4:0] OpNot  = 5'b10010;

    function automatic logic is_binary(input logic [4:0] op);
        return op inside {OpAdd, OpSub, OpAnd, OpOr, OpRor, OpRol, OpShr, OpShra, OpShl};
    endfunction

    function automatic logic is_unary(input logic [4:0] op);
        return op inside {OpNeg, OpNot};
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        return op inside {OpMul, OpDiv};
    endfunction

endpackage

// File: rtl/alu_op_sequencer_reg_select_decoder.sv
// Register-select decoder: 4-bit register index to NREG-wide one-hot select.
//   idx    : register index
//   en     : decode enable; when low the one-hot output and flag are 0
//   onehot : one-hot select (all zero when disabled or out of range)
//   oor    : enabled index names a register that does not exist (>= NREG)
module reg_select_decoder #(
    parameter int unsigned NREG = 16
) (
    input  logic [3:0]      idx,
    input  logic            en,
    output logic [NREG-1:0] onehot,
    output logic            oor
);

    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            onehot[i] = en && (idx == 4'(i));
        end
        oor = en && ({28'd0, idx} >= NREG);
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU instruction sequencer: steps one fetched instruction through the
// control steps T0..T6 and drives the datapath enables for each step.
//   clk, clr          : clock and synchronous active-high reset
//   start             : launch one instruction (sampled only in IDLE)
//   ir_in             : instruction word on the bus (captured at end of T2)
//   mem_ack           : memory read complete (sampled only in T1)
//   Rin, Rout         : one-hot general-register load / drive selects
//   PCout..LOin       : datapath load/drive controls
//   ALUopcode         : ALU operation select (non-zero only in T4)
//   busy, done, illegal : status; done and illegal are one-cycle pulses
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int unsigned NREG = 16,
    parameter int unsigned OPW  = 5
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            start,
    input  logic [31:0]     ir_in,
    input  logic            mem_ack,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout,
    output logic            PCout,
    output logic            PCin,
    output logic            MARin,
    output logic            IncPC,
    output logic            Read,
    output logic            MDRin,
    output logic            MDRout,
    output logic            IRin,
    output logic            Yin,
    output logic            Zlowin,
    output logic            Zhighin,
    output logic            Zlowout,
    output logic            Zhighout,
    output logic            HIin,
    output logic            LOin,
    output logic [OPW-1:0]  ALUopcode,
    output logic            busy,
    output logic            done,
    output logic            illegal
);

    state_e          state_q;
    logic [31:0]     ir_q;
    logic            illegal_q;

    logic [31:0]     ir_src;
    logic [4:0]      op_src;
    logic            bin_op;
    logic            un_op;
    logic            md_op;
    logic            legal_op;
    logic [NREG-1:0] sel_a;
    logic [NREG-1:0] sel_b;
    logic [NREG-1:0] sel_c;
    logic            oor_a;
    logic            oor_b;
    logic            oor_c;
    logic            bad_instr;

    // In T2 the word is still on the bus, so decode it directly for the
    // legality check; in later steps decode the latched copy.
    always_comb begin
        ir_src   = (state_q == StT2) ? ir_in : ir_q;
        op_src   = ir_src[OpMsb:OpLsb];
        bin_op   = is_binary(op_src);
        un_op    = is_unary(op_src);
        md_op    = is_muldiv(op_src);
        legal_op = bin_op || un_op || md_op;
    end

    // Rc is only a source for binary ops, so only then can it be out of range.
    reg_select_decoder #(.NREG(NREG)) u_dec_a (
        .idx    (ir_src[RaMsb:RaLsb]),
        .en     (legal_op),
        .onehot (sel_a),
        .oor    (oor_a)
    );

    reg_select_decoder #(.NREG(NREG)) u_dec_b (
        .idx    (ir_src[RbMsb:RbLsb]),
        .en     (legal_op),
        .onehot (sel_b),
        .oor    (oor_b)
    );

    reg_select_decoder #(.NREG(NREG)) u_dec_c (
        .idx    (ir_src[RcMsb:RcLsb]),
        .en     (bin_op),
        .onehot (sel_c),
        .oor    (oor_c)
    );

    always_comb begin
        bad_instr = !legal_op || oor_a || oor_b || oor_c;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= StIdle;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            case (state_q)
                StIdle: if (start) state_q <= StT0;
                StT0:   state_q <= StT1;
                StT1:   if (mem_ack) state_q <= StT2;
                StT2: begin
                    ir_q <= ir_in;
                    if (bad_instr) begin
                        state_q   <= StIdle;
                        illegal_q <= 1'b1;
                    end else if (un_op) begin
                        state_q <= StT4;
                    end else begin
                        state_q <= StT3;
                    end
                end
                StT3:   state_q <= StT4;
                StT4:   state_q <= StT5;
                StT5:   state_q <= md_op ? StT6 : StIdle;
                StT6:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        Rin       = '0;
        Rout      = '0;
        PCout     = 1'b0;
        PCin      = 1'b0;
        MARin     = 1'b0;
        IncPC     = 1'b0;
        Read      = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Zlowin    = 1'b0;
        Zhighin   = 1'b0;
        Zlowout   = 1'b0;
        Zhighout  = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        ALUopcode = '0;
        done      = 1'b0;
        case (state_q)
            StT0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zlowin  = 1'b1;
                Zhighin = 1'b1;
            end
            StT1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            StT2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            StT3: begin
                Rout = md_op ? sel_a : sel_b;
                Yin  = 1'b1;
            end
            StT4: begin
                Rout      = bin_op ? sel_c : sel_b;
                ALUopcode = OPW'(op_src);
                Zlowin    = 1'b1;
                Zhighin   = 1'b1;
            end
            StT5: begin
                Zlowout = 1'b1;
                if (md_op) begin
                    LOin = 1'b1;
                end else begin
                    Rin  = sel_a;
                    done = 1'b1;
                end
            end
            StT6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy    = (state_q != StIdle);
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    localparam int MaxCyc = 12;

    // Control vector bit order: PCout PCin MARin IncPC Read MDRin MDRout IRin
    //                           Yin Zlowin Zhighin Zlowout Zhighout HIin LOin
    localparam logic [14:0] CPcOut   = 15'h4000;
    localparam logic [14:0] CPcIn    = 15'h2000;
    localparam logic [14:0] CMarIn   = 15'h1000;
    localparam logic [14:0] CIncPc   = 15'h0800;
    localparam logic [14:0] CRead    = 15'h0400;
    localparam logic [14:0] CMdrIn   = 15'h0200;
    localparam logic [14:0] CMdrOut  = 15'h0100;
    localparam logic [14:0] CIrIn    = 15'h0080;
    localparam logic [14:0] CYIn     = 15'h0040;
    localparam logic [14:0] CZlIn    = 15'h0020;
    localparam logic [14:0] CZhIn    = 15'h0010;
    localparam logic [14:0] CZlOut   = 15'h0008;
    localparam logic [14:0] CZhOut   = 15'h0004;
    localparam logic [14:0] CHiIn    = 15'h0002;
    localparam logic [14:0] CLoIn    = 15'h0001;
    localparam logic [14:0] CtlT0    = CPcOut | CMarIn | CIncPc | CZlIn | CZhIn;
    localparam logic [14:0] CtlT1    = CZlOut | CPcIn | CRead | CMdrIn;
    localparam logic [14:0] CtlT2    = CMdrOut | CIrIn;
    localparam logic [14:0] CtlT3    = CYIn;
    localparam logic [14:0] CtlT4    = CZlIn | CZhIn;
    localparam logic [14:0] CtlT5    = CZlOut;
    localparam logic [14:0] CtlT5Md  = CZlOut | CLoIn;
    localparam logic [14:0] CtlT6    = CZhOut | CHiIn;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr, start, mem_ack;
    logic [31:0] ir_in;

    logic [15:0] rin, rout;
    logic [14:0] ctl;
    logic [4:0]  alu;
    logic        busy, done, illegal;

    logic [7:0]  rin8, rout8;
    logic [14:0] ctl8;
    logic [4:0]  alu8;
    logic        busy8, done8, illegal8;

    logic [54:0] all16;
    logic [40:0] all8;
    assign all16 = {busy, done, illegal, ctl, alu, rin, rout};
    assign all8  = {busy8, done8, illegal8, ctl8, alu8, rin8, rout8};

    alu_op_sequencer #(.NREG(16), .OPW(5)) dut (
        .clk(clk), .clr(clr), .start(start), .ir_in(ir_in), .mem_ack(mem_ack),
        .Rin(rin), .Rout(rout),
        .PCout(ctl[14]), .PCin(ctl[13]), .MARin(ctl[12]), .IncPC(ctl[11]), .Read(ctl[10]),
        .MDRin(ctl[9]), .MDRout(ctl[8]), .IRin(ctl[7]), .Yin(ctl[6]), .Zlowin(ctl[5]),
        .Zhighin(ctl[4]), .Zlowout(ctl[3]), .Zhighout(ctl[2]), .HIin(ctl[1]), .LOin(ctl[0]),
        .ALUopcode(alu), .busy(busy), .done(done), .illegal(illegal)
    );

    alu_op_sequencer #(.NREG(8), .OPW(5)) dut8 (
        .clk(clk), .clr(clr), .start(start), .ir_in(ir_in), .mem_ack(mem_ack),
        .Rin(rin8), .Rout(rout8),
        .PCout(ctl8[14]), .PCin(ctl8[13]), .MARin(ctl8[12]), .IncPC(ctl8[11]),
        .Read(ctl8[10]), .MDRin(ctl8[9]), .MDRout(ctl8[8]), .IRin(ctl8[7]), .Yin(ctl8[6]),
        .Zlowin(ctl8[5]), .Zhighin(ctl8[4]), .Zlowout(ctl8[3]), .Zhighout(ctl8[2]),
        .HIin(ctl8[1]), .LOin(ctl8[0]),
        .ALUopcode(alu8), .busy(busy8), .done(done8), .illegal(illegal8)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] l_rin  [0:MaxCyc];
    logic [15:0] l_rout [0:MaxCyc];
    logic [14:0] l_ctl  [0:MaxCyc];
    logic [4:0]  l_alu  [0:MaxCyc];
    logic        l_done [0:MaxCyc];
    logic        l_ill  [0:MaxCyc];
    logic        l_busy [0:MaxCyc];

    typedef struct {
        string       name;
        logic [31:0] ir;
        int          waits;
        bit          use8;
        int          done_cyc;  // 0: no done expected
        int          ill_cyc;   // 0: no illegal expected
        int          t4_cyc;    // 0: instruction never reaches T4
        logic [15:0] pre_rout;  // Rout in the cycle before T4
        logic [14:0] pre_ctl;   // controls in the cycle before T4
        logic [15:0] t4_rout;
        logic [4:0]  alu;
        logic [15:0] rin_or;
        int          lo_cyc;    // 0: no LOin step
        logic [14:0] done_ctl;
        int          read_cnt;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sample(input int c, input bit use8);
        if (use8) begin
            l_rin[c]  = {8'h00, rin8};
            l_rout[c] = {8'h00, rout8};
            l_ctl[c]  = ctl8;
            l_alu[c]  = alu8;
            l_done[c] = done8;
            l_ill[c]  = illegal8;
            l_busy[c] = busy8;
        end else begin
            l_rin[c]  = rin;
            l_rout[c] = rout;
            l_ctl[c]  = ctl;
            l_alu[c]  = alu;
            l_done[c] = done;
            l_ill[c]  = illegal;
            l_busy[c] = busy;
        end
    endtask

    // start is sampled at edge 0; cycle c is the cycle after edge c-1.
    task automatic run_instr(input logic [31:0] ir, input int waits, input bit use8);
        @(negedge clk);
        ir_in   = ir;
        start   = 1'b1;
        mem_ack = 1'b0;
        for (int c = 1; c <= MaxCyc; c++) begin
            @(negedge clk);
            start = 1'b0;
            sample(c, use8);
            mem_ack = (c >= 2 + waits);
        end
    endtask

    // Watch the NREG=16 instance for n cycles; nothing may happen.
    task automatic expect_quiet(input string name, input int n);
        int ev_done, ev_ill, ev_busy;
        logic [15:0] ev_rin;
        ev_done = 0; ev_ill = 0; ev_busy = 0; ev_rin = '0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (done) ev_done++;
            if (illegal) ev_ill++;
            if (busy) ev_busy++;
            ev_rin |= rin;
        end
        check({name, " done"}, 64'(ev_done), 64'd0);
        check({name, " illegal"}, 64'(ev_ill), 64'd0);
        check({name, " busy"}, 64'(ev_busy), 64'd0);
        check({name, " Rin"}, 64'(ev_rin), 64'd0);
    endtask

    initial begin
        int dcyc, dcnt, icyc, icnt, anz, rdc;
        logic [15:0] rin_or;
        int d1, d2, dn;
        logic [14:0] exp_ctl;

        vecs[0]  = '{"and_r1r2r3", 32'h28918000, 0, 1'b0, 6, 0, 5, 16'h0004, CtlT3,
                     16'h0008, 5'b00101, 16'h0002, 0, CtlT5, 1};
        vecs[1]  = '{"mul_r4r2", 32'h7A100000, 0, 1'b0, 7, 0, 5, 16'h0010, CtlT3,
                     16'h0004, 5'b01111, 16'h0000, 6, CtlT6, 1};
        vecs[2]  = '{"and_wait3", 32'h28918000, 3, 1'b0, 9, 0, 8, 16'h0004, CtlT3,
                     16'h0008, 5'b00101, 16'h0002, 0, CtlT5, 4};
        vecs[3]  = '{"neg_r2r2", 32'h89100000, 0, 1'b0, 5, 0, 4, 16'h0000, CtlT2,
                     16'h0004, 5'b10001, 16'h0004, 0, CtlT5, 1};
        vecs[4]  = '{"shl_r15r14r13", 32'h5FF68000, 0, 1'b0, 6, 0, 5, 16'h4000, CtlT3,
                     16'h2000, 5'b01011, 16'h8000, 0, CtlT5, 1};
        vecs[5]  = '{"and_rc9_n16", 32'h28948000, 0, 1'b0, 6, 0, 5, 16'h0004, CtlT3,
                     16'h0200, 5'b00101, 16'h0002, 0, CtlT5, 1};
        vecs[6]  = '{"and_rc9_n8", 32'h28948000, 0, 1'b1, 0, 4, 0, 16'h0000, 15'h0,
                     16'h0000, 5'b00000, 16'h0000, 0, 15'h0, 1};
        vecs[7]  = '{"op11111", 32'hF8000000, 0, 1'b0, 0, 4, 0, 16'h0000, 15'h0,
                     16'h0000, 5'b00000, 16'h0000, 0, 15'h0, 1};
        vecs[8]  = '{"mul_ra9_n8", 32'h7C900000, 0, 1'b1, 0, 4, 0, 16'h0000, 15'h0,
                     16'h0000, 5'b00000, 16'h0000, 0, 15'h0, 1};
        vecs[9]  = '{"neg_rc9_n8", 32'h89148000, 0, 1'b1, 5, 0, 4, 16'h0000, CtlT2,
                     16'h0004, 5'b10001, 16'h0004, 0, CtlT5, 1};
        vecs[10] = '{"div_r3r5_wait1", 32'h81A80000, 1, 1'b0, 8, 0, 6, 16'h0008, CtlT3,
                     16'h0020, 5'b10000, 16'h0000, 7, CtlT6, 2};

        // Reset state
        clr = 1'b1; start = 1'b0; mem_ack = 1'b0; ir_in = '0;
        repeat (2) @(negedge clk);
        check("reset outputs n16", 64'(all16), 64'd0);
        check("reset outputs n8", 64'(all8), 64'd0);
        clr = 1'b0;

        // Table-driven instructions
        for (int v = 0; v < 11; v++) begin
            run_instr(vecs[v].ir, vecs[v].waits, vecs[v].use8);
            dcyc = 0; dcnt = 0; icyc = 0; icnt = 0; anz = 0; rdc = 0; rin_or = '0;
            for (int c = 1; c <= MaxCyc; c++) begin
                if (l_done[c]) begin dcnt++; if (dcyc == 0) dcyc = c; end
                if (l_ill[c]) begin icnt++; if (icyc == 0) icyc = c; end
                if (l_alu[c] != 5'd0) anz++;
                if ((l_ctl[c] & CRead) != 15'd0) rdc++;
                rin_or |= l_rin[c];
            end
            check({vecs[v].name, " done_cycle"}, 64'(dcyc), 64'(vecs[v].done_cyc));
            check({vecs[v].name, " done_count"}, 64'(dcnt), 64'(vecs[v].done_cyc != 0));
            check({vecs[v].name, " illegal_cycle"}, 64'(icyc), 64'(vecs[v].ill_cyc));
            check({vecs[v].name, " illegal_count"}, 64'(icnt), 64'(vecs[v].ill_cyc != 0));
            check({vecs[v].name, " Rin_union"}, 64'(rin_or), 64'(vecs[v].rin_or));
            check({vecs[v].name, " read_cycles"}, 64'(rdc), 64'(vecs[v].read_cnt));
            check({vecs[v].name, " alu_nonzero_cycles"}, 64'(anz),
                  64'(vecs[v].t4_cyc != 0));
            check({vecs[v].name, " ctl_T0"}, 64'(l_ctl[1]), 64'(CtlT0));
            check({vecs[v].name, " ctl_T1"}, 64'(l_ctl[2]), 64'(CtlT1));
            check({vecs[v].name, " ctl_T2"}, 64'(l_ctl[3 + vecs[v].waits]), 64'(CtlT2));
            if (vecs[v].t4_cyc != 0) begin
                check({vecs[v].name, " Rout_preT4"}, 64'(l_rout[vecs[v].t4_cyc - 1]),
                      64'(vecs[v].pre_rout));
                check({vecs[v].name, " ctl_preT4"}, 64'(l_ctl[vecs[v].t4_cyc - 1]),
                      64'(vecs[v].pre_ctl));
                check({vecs[v].name, " Rout_T4"}, 64'(l_rout[vecs[v].t4_cyc]),
                      64'(vecs[v].t4_rout));
                check({vecs[v].name, " ctl_T4"}, 64'(l_ctl[vecs[v].t4_cyc]), 64'(CtlT4));
                check({vecs[v].name, " alu_T4"}, 64'(l_alu[vecs[v].t4_cyc]),
                      64'(vecs[v].alu));
            end
            if (vecs[v].done_cyc != 0) begin
                check({vecs[v].name, " ctl_done"}, 64'(l_ctl[vecs[v].done_cyc]),
                      64'(vecs[v].done_ctl));
                check({vecs[v].name, " busy_after_done"},
                      64'(l_busy[vecs[v].done_cyc + 1]), 64'd0);
            end
            if (vecs[v].lo_cyc != 0) begin
                check({vecs[v].name, " ctl_LO"}, 64'(l_ctl[vecs[v].lo_cyc]), 64'(CtlT5Md));
            end
            if (vecs[v].ill_cyc != 0) begin
                check({vecs[v].name, " busy_at_illegal"}, 64'(l_busy[vecs[v].ill_cyc]),
                      64'd0);
                check({vecs[v].name, " ctl_at_illegal"}, 64'(l_ctl[vecs[v].ill_cyc]),
                      64'd0);
            end
        end

        // clr during T4 aborts cleanly, then a normal instruction completes
        @(negedge clk);
        ir_in = 32'h28918000; start = 1'b1; mem_ack = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("clrT4 in_T4 alu", 64'(alu), 64'(5'b00101));
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clrT4 outputs after clr", 64'(all16), 64'd0);
        expect_quiet("clrT4 aftermath", 6);
        run_instr(32'h28918000, 0, 1'b0);
        dcyc = 0;
        for (int c = MaxCyc; c >= 1; c--) if (l_done[c]) dcyc = c;
        check("clrT4 rerun done_cycle", 64'(dcyc), 64'd6);
        check("clrT4 rerun Rin", 64'(l_rin[6]), 64'h0002);

        // clr in a T1 wait with start and mem_ack also high: clr wins
        @(negedge clk);
        ir_in = 32'h28918000; start = 1'b1; mem_ack = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("clrT1 in_T1 ctl", 64'(ctl), 64'(CtlT1));
        clr = 1'b1; start = 1'b1; mem_ack = 1'b1;
        @(negedge clk);
        clr = 1'b0; start = 1'b0;
        check("clrT1 outputs after clr", 64'(all16), 64'd0);
        expect_quiet("clrT1 aftermath", 6);

        // start held high: ignored while busy, relaunches from IDLE after done
        @(negedge clk);
        ir_in = 32'h28918000; start = 1'b1; mem_ack = 1'b1;
        d1 = 0; d2 = 0; dn = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (done) begin
                dn++;
                if (d1 == 0) d1 = c; else if (d2 == 0) d2 = c;
            end
            if (c == 7) check("held_start busy_c7", 64'(busy), 64'd0);
            if (c == 8) begin
                exp_ctl = CtlT0;
                check("held_start ctl_c8", 64'(ctl), 64'(exp_ctl));
            end
            if (c == 14) check("held_start busy_c14", 64'(busy), 64'd0);
        end
        start = 1'b0;
        check("held_start first_done", 64'(d1), 64'd6);
        check("held_start second_done", 64'(d2), 64'd13);
        check("held_start done_count", 64'(dn), 64'd2);
        expect_quiet("held_start end", 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
